// File: rtl/complex_acc_pkg.sv
// complex_acc_pkg
// Shared definitions for the complex integrate-and-dump block:
//   - default widths for the input samples, the accumulators and the output
//   - the two-state frame FSM encoding
//   - saturation limits of a signed OUT_W-bit result
package complex_acc_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_N     = 16;
    localparam int DEF_ACC_W = 16;
    localparam int DEF_OUT_W = 12;

    typedef enum logic {
        ST_IDLE = 1'b0,   // no partial frame, count == 0
        ST_ACC  = 1'b1    // at least one sample of the frame is in the accumulators
    } state_t;

    // Largest value representable in a signed w-bit word.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Smallest value representable in a signed w-bit word.
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/complex_acc_dump_if.sv
// complex_acc_dump_if
// Sample stream into, and frame results out of, complex_acc_dump.
//   clear     : frame abort (discard partial sum, restart count)
//   in_valid  : in_re/in_im carry a product this cycle
//   in_re/im  : signed product components, IN_W bits
//   out_valid : one-cycle pulse with a new frame result
//   out_re/im : signed saturated frame sums, OUT_W bits (held between frames)
//   out_sat   : either component of the held result saturated
//   busy      : a partial frame is in progress
// slave  : the accumulator block
// master : the producer feeding it and consuming the results
interface complex_acc_dump_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 12
) ();

    logic                    clear;
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_re;
    logic signed [IN_W-1:0]  in_im;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_re;
    logic signed [OUT_W-1:0] out_im;
    logic                    out_sat;
    logic                    busy;

    modport slave (
        input  clear, in_valid, in_re, in_im,
        output out_valid, out_re, out_im, out_sat, busy
    );

    modport master (
        output clear, in_valid, in_re, in_im,
        input  out_valid, out_re, out_im, out_sat, busy
    );

endinterface

// File: rtl/complex_acc_dump_acc_lane.sv
// acc_lane
// One component (real or imaginary) of the integrate-and-dump datapath.
// Holds a signed ACC_W accumulator and the registered, saturated OUT_W result.
//   clk, rst : clock and synchronous active-high reset
//   clr      : zero the accumulator (highest priority after rst)
//   load     : accumulator <= sign-extended sample (first sample of a frame)
//   add      : accumulator <= accumulator + sample
//   dump     : result <= sat(accumulator + sample), accumulator <= 0
//   sample   : signed IN_W input component
//   out      : held saturated result
//   sat      : held flag, result was clipped
module acc_lane
    import complex_acc_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    load,
    input  logic                    add,
    input  logic                    dump,
    input  logic signed [IN_W-1:0]  sample,
    output logic signed [OUT_W-1:0] out,
    output logic                    sat
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(OUT_W));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(OUT_W));

    function automatic logic signed [OUT_W-1:0] sat_val(input logic signed [ACC_W-1:0] x);
        if (x > MAX_V) return OUT_W'(MAX_V);
        if (x < MIN_V) return OUT_W'(MIN_V);
        return x[OUT_W-1:0];
    endfunction

    function automatic logic is_sat(input logic signed [ACC_W-1:0] x);
        return (x > MAX_V) || (x < MIN_V);
    endfunction

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic                    sat_q, sat_d;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] full;

    always_comb begin
        // Signed size cast sign-extends the sample to accumulator width.
        sample_ext = ACC_W'(sample);
        full       = acc_q + sample_ext;
        acc_d      = acc_q;
        out_d      = out_q;
        sat_d      = sat_q;
        if (clr) begin
            acc_d = '0;
        end else if (load) begin
            acc_d = sample_ext;
        end else if (add) begin
            acc_d = full;
        end else if (dump) begin
            // The last sample never lands in acc_q; the result is taken from
            // the combinational sum so the next frame can load on the next edge.
            acc_d = '0;
            out_d = sat_val(full);
            sat_d = is_sat(full);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            out_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
            sat_q <= sat_d;
        end
    end

    assign out = out_q;
    assign sat = sat_q;

endmodule

// File: rtl/complex_acc_dump.sv
// complex_acc_dump
// Integrate-and-dump back end for the complex multiplier: sums N consecutive
// valid signed complex products and emits one saturated complex result per
// frame with a one-cycle out_valid pulse. Frames may follow back to back.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (priority over clear and in_valid)
//   bus : complex_acc_dump_if slave modport (clear, in_valid, in_re, in_im,
//         out_valid, out_re, out_im, out_sat, busy)
module complex_acc_dump
    import complex_acc_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int N     = DEF_N,
    parameter int ACC_W = DEF_ACC_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    complex_acc_dump_if.slave bus
);

    if (N < 2 || N > 256) begin : g_bad_n
        $error("complex_acc_dump: N=%0d outside legal range 2..256", N);
    end
    if (ACC_W < IN_W + $clog2(N)) begin : g_bad_acc_w
        $error("complex_acc_dump: ACC_W=%0d too narrow for IN_W=%0d, N=%0d", ACC_W, IN_W, N);
    end

    localparam int             CNT_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             lane_load, lane_add, lane_dump;
    logic             sat_re, sat_im;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = 1'b0;
        lane_load   = 1'b0;
        lane_add    = 1'b0;
        lane_dump   = 1'b0;
        // clear wins over a coincident sample, even the last one of a frame.
        if (bus.clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (bus.in_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    lane_load = 1'b1;
                    count_d   = CNT_W'(1);
                    state_d   = ST_ACC;
                end
                ST_ACC: begin
                    if (count_q == LAST) begin
                        lane_dump   = 1'b1;
                        out_valid_d = 1'b1;
                        count_d     = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        lane_add = 1'b1;
                        count_d  = count_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane_re (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.clear),
        .load   (lane_load),
        .add    (lane_add),
        .dump   (lane_dump),
        .sample (bus.in_re),
        .out    (bus.out_re),
        .sat    (sat_re)
    );

    acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane_im (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.clear),
        .load   (lane_load),
        .add    (lane_add),
        .dump   (lane_dump),
        .sample (bus.in_im),
        .out    (bus.out_im),
        .sat    (sat_im)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_sat   = sat_re | sat_im;
    assign bus.busy      = (state_q == ST_ACC);

endmodule
